// File: rtl/systolic_input_skew.sv
// systolic_input_skew: skews row vectors into diagonal lanes, then drains with zero bubbles and pulses done.
// Optional vec_count port/counter enabled by defining SYSTOLIC_SKEW_COUNT_EN.
module systolic_input_skew #(
  parameter int DATA_WIDTH  = 8,
  parameter int SIZE        = 4,
  parameter int DRAIN_EXTRA = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  input  logic                       arr_stall,
  output logic [SIZE*DATA_WIDTH-1:0] arr_data,
  output logic [SIZE-1:0]            arr_valid,
  output logic                       busy,
  output logic                       done
`ifdef SYSTOLIC_SKEW_COUNT_EN
  ,
  output logic [15:0]                vec_count
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  localparam int CW = $clog2(SIZE + DRAIN_EXTRA + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(SIZE - 1 + DRAIN_EXTRA);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          adv, accept, drain_end;
  assign adv       = !arr_stall;
  assign accept    = in_valid && in_ready;
  assign drain_end = state_q == DRAIN && adv && cnt_q == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  // accept can never happen in DRAIN because in_ready is low there
  always_comb begin
    state_d = state_q;
    if (accept) state_d = in_last ? DRAIN : STREAM;
    if (drain_end) state_d = IDLE;
  end
  always_comb begin
    in_ready = adv && state_q != DRAIN;
    busy     = state_q != IDLE;
    done     = done_q;
    done_d   = drain_end;
    cnt_d    = (accept && in_last) ? DRAIN_LOAD :
               (state_q == DRAIN && adv && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  // lane i is a chain of i+1 registers; bubbles carry zero data
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] d_q [0:i];
    logic                  v_q [0:i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          d_q[s] <= '0;
          v_q[s] <= 1'b0;
        end
      end else if (adv) begin
        d_q[0] <= accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        v_q[0] <= accept;
        for (int s = 1; s <= i; s++) begin
          d_q[s] <= d_q[s-1];
          v_q[s] <= v_q[s-1];
        end
      end
    end
    assign arr_data[i*DATA_WIDTH +: DATA_WIDTH] = v_q[i] ? d_q[i] : '0;
    assign arr_valid[i] = v_q[i];
  end
`ifdef SYSTOLIC_SKEW_COUNT_EN
  logic [15:0] vec_q, vec_d;
  always_comb
    vec_d = !accept ? vec_q : (state_q == IDLE) ? 16'd1 : (vec_q == 16'hFFFF) ? vec_q : vec_q + 16'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vec_q <= '0;
    else vec_q <= vec_d;
  end
  assign vec_count = vec_q;
`endif
endmodule

// File: tb/tb_systolic_input_skew.sv
// tb_systolic_input_skew: directed checks of skew timing, bubbles, stalls, drain and reset abort.
module tb_systolic_input_skew;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        arr_stall = 1'b0;
  logic [31:0] arr_data;
  logic [3:0]  arr_valid;
  logic        busy;
  logic        done;
`ifdef SYSTOLIC_SKEW_COUNT_EN
  logic [15:0] vec_count;
`endif
  int tests = 0;
  int fails = 0;

  systolic_input_skew dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .arr_stall(arr_stall),
    .arr_data(arr_data), .arr_valid(arr_valid), .busy(busy), .done(done)
`ifdef SYSTOLIC_SKEW_COUNT_EN
    , .vec_count(vec_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vec(input int j);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(j*16 + i);
    return v;
  endfunction

  // slot p is the p-th non-stalled edge; acc marks which slots carry a vector, slot last has in_last
  task automatic xfer(input logic [7:0] acc, input int last, input logic [63:0] stl, input string nm);
    int p = 0;
    int t = 0;
    int n, k, cnt;
    logic s;
    logic [3:0]  ev;
    logic [31:0] ed;
    while (p <= last + 9 && t < 64) begin
      s = stl[t];
      arr_stall = s;
      in_valid = (p <= last) ? acc[p] : (p <= last + 8);
      in_last = (p == last);
      in_data = (p <= last && acc[p]) ? vec(p) : 32'hFFFF_FFFF;
      #1;
      chk({nm, "_in_ready"}, in_ready, !s && !(p >= last + 1 && p <= last + 8));
      @(posedge clk);
      #2;
      if (!s) p++;
      n = p - 1;
      ev = '0;
      ed = '0;
      for (int i = 0; i < 4; i++) begin
        k = n - i;
        if (k >= 0 && k <= last && acc[k]) begin
          ev[i] = 1'b1;
          ed[i*8 +: 8] = 8'(k*16 + i);
        end
      end
      chk({nm, "_arr_valid"}, arr_valid, ev);
      chk({nm, "_arr_data"}, arr_data, ed);
      chk({nm, "_done"}, done, !s && n == last + 8);
      chk({nm, "_busy"}, busy, p >= 1 && p <= last + 8);
      t++;
    end
    chk({nm, "_timeout"}, t < 64, 1'b1);
    in_valid = 1'b0;
    in_last = 1'b0;
    arr_stall = 1'b0;
    cnt = 0;
    for (int j = 0; j <= last; j++) cnt += int'(acc[j]);
`ifdef SYSTOLIC_SKEW_COUNT_EN
    chk({nm, "_vec_count"}, vec_count, 64'(cnt));
`endif
  endtask

  initial begin
    #12;
    chk("reset_arr_valid", arr_valid, 4'h0);
    chk("reset_arr_data", arr_data, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
`ifdef SYSTOLIC_SKEW_COUNT_EN
    chk("reset_vec_count", vec_count, 16'h0);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    xfer(8'b0000_0001, 0, 64'h0, "single");
    xfer(8'b0000_1111, 3, 64'h0, "burst4");
    xfer(8'b0000_0101, 2, 64'h0, "bubble");
    xfer(8'b0000_1111, 3, (64'h7 << 1) | (64'h7 << 9), "stall");
    // abort in DRAIN after the counter has stepped 7 -> 4
    in_valid = 1'b1;
    in_last = 1'b1;
    in_data = vec(0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_abort_lane3", arr_valid, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("abort_arr_valid", arr_valid, 4'h0);
    chk("abort_arr_data", arr_data, 32'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #2;
      chk("post_abort_no_done", done, 1'b0);
    end
    xfer(8'b0000_0001, 0, 64'h0, "after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
